// File: rtl/input_debounce.sv
// Multi-channel 2-FF synchronizer and strobe-paced debouncer with edge pulses and irq.
// Optional sticky edge flags are enabled by defining DEBOUNCE_EDGE_LATCH_EN.
module input_debounce #(
  parameter int unsigned    NUM            = 7,
  parameter int unsigned    STABLE_SAMPLES = 20,
  parameter logic [NUM-1:0] INIT_LEVEL     = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sample_en,
  input  logic [NUM-1:0] raw,
  output logic [NUM-1:0] level,
  output logic [NUM-1:0] rise,
  output logic [NUM-1:0] fall,
  input  logic [NUM-1:0] flag_clr,
  output logic [NUM-1:0] rise_flag,
  output logic [NUM-1:0] fall_flag,
  output logic           irq
);

  localparam int unsigned   CW      = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(STABLE_SAMPLES - 1);

  typedef enum logic [1:0] {StStableLo, StChkHi, StStableHi, StChkLo} state_e;

  state_e         r_state   [NUM];
  state_e         w_state_d [NUM];
  logic [CW-1:0]  r_cnt     [NUM];
  logic [CW-1:0]  w_cnt_d   [NUM];
  logic [NUM-1:0] r_meta, r_sync;
  logic [NUM-1:0] r_level, w_level_d;
  logic [NUM-1:0] r_rise, w_rise_d;
  logic [NUM-1:0] r_fall, w_fall_d;
  logic           r_irq, w_irq_d;

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_state_d[i] = r_state[i];
      w_cnt_d[i]   = r_cnt[i];
    end
    w_level_d = r_level;
    w_rise_d  = '0;
    w_fall_d  = '0;
    if (sample_en) begin
      for (int i = 0; i < NUM; i++) begin
        unique case (r_state[i])
          StStableLo: begin
            if (r_sync[i]) begin
              if (STABLE_SAMPLES == 1) begin
                w_state_d[i] = StStableHi;
                w_level_d[i] = 1'b1;
                w_rise_d[i]  = 1'b1;
              end else begin
                w_state_d[i] = StChkHi;
                w_cnt_d[i]   = CW'(1);
              end
            end
          end
          StChkHi: begin
            if (!r_sync[i]) begin
              w_state_d[i] = StStableLo;
              w_cnt_d[i]   = '0;
            end else if (r_cnt[i] == CntLast) begin
              w_state_d[i] = StStableHi;
              w_cnt_d[i]   = '0;
              w_level_d[i] = 1'b1;
              w_rise_d[i]  = 1'b1;
            end else begin
              w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
          end
          StStableHi: begin
            if (!r_sync[i]) begin
              if (STABLE_SAMPLES == 1) begin
                w_state_d[i] = StStableLo;
                w_level_d[i] = 1'b0;
                w_fall_d[i]  = 1'b1;
              end else begin
                w_state_d[i] = StChkLo;
                w_cnt_d[i]   = CW'(1);
              end
            end
          end
          StChkLo: begin
            if (r_sync[i]) begin
              w_state_d[i] = StStableHi;
              w_cnt_d[i]   = '0;
            end else if (r_cnt[i] == CntLast) begin
              w_state_d[i] = StStableLo;
              w_cnt_d[i]   = '0;
              w_level_d[i] = 1'b0;
              w_fall_d[i]  = 1'b1;
            end else begin
              w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= INIT_LEVEL;
      r_sync  <= INIT_LEVEL;
      r_level <= INIT_LEVEL;
      r_rise  <= '0;
      r_fall  <= '0;
      r_irq   <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        r_state[i] <= INIT_LEVEL[i] ? StStableHi : StStableLo;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_meta  <= raw;
      r_sync  <= r_meta;
      r_level <= w_level_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
      r_irq   <= w_irq_d;
      for (int i = 0; i < NUM; i++) begin
        r_state[i] <= w_state_d[i];
        r_cnt[i]   <= w_cnt_d[i];
      end
    end
  end

`ifdef DEBOUNCE_EDGE_LATCH_EN
  logic [NUM-1:0] r_rise_flag, r_fall_flag;

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_flag <= '0;
      r_fall_flag <= '0;
    end else begin
      r_rise_flag <= (r_rise_flag & ~flag_clr) | r_rise;
      r_fall_flag <= (r_fall_flag & ~flag_clr) | r_fall;
    end
  end

  assign w_irq_d   = |(r_rise_flag | r_fall_flag);
  assign rise_flag = r_rise_flag;
  assign fall_flag = r_fall_flag;
`else
  logic w_unused_clr;

  assign w_unused_clr = ^flag_clr;
  assign w_irq_d      = |(r_rise | r_fall);
  assign rise_flag    = '0;
  assign fall_flag    = '0;
`endif

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign irq   = r_irq;

endmodule

// File: tb/tb_input_debounce.sv
// Randomized and directed bench for input_debounce against a per-channel run-length model.
// Works with or without DEBOUNCE_EDGE_LATCH_EN defined.
module tb_input_debounce;

  localparam int         NUM  = 7;
  localparam int         S    = 4;
  localparam logic [6:0] INIT = 7'b0001001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sample_en = 1'b0;
  logic [6:0] raw = INIT;
  logic [6:0] flag_clr = '0;
  logic [6:0] level, rise, fall, rise_flag, fall_flag;
  logic       irq;

  input_debounce #(
    .NUM           (NUM),
    .STABLE_SAMPLES(S),
    .INIT_LEVEL    (INIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(sample_en),
    .raw      (raw),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .flag_clr (flag_clr),
    .rise_flag(rise_flag),
    .fall_flag(fall_flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel accepts once sync has differed from level on S consecutive strobes.
  logic [6:0] m_meta, m_sync, m_level, m_rise, m_fall, m_rflag, m_fflag;
  logic [6:0] t_nr, t_nf;
  logic       m_irq;
  int         m_run [NUM];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta = INIT; m_sync = INIT; m_level = INIT;
      m_rise = '0; m_fall = '0; m_rflag = '0; m_fflag = '0; m_irq = 1'b0;
      for (int i = 0; i < NUM; i++) m_run[i] = 0;
    end else begin
`ifdef DEBOUNCE_EDGE_LATCH_EN
      m_irq   = |(m_rflag | m_fflag);
      m_rflag = (m_rflag & ~flag_clr) | m_rise;
      m_fflag = (m_fflag & ~flag_clr) | m_fall;
`else
      m_irq = |(m_rise | m_fall);
`endif
      t_nr = '0;
      t_nf = '0;
      if (sample_en) begin
        for (int i = 0; i < NUM; i++) begin
          if (m_sync[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == S) begin
              m_level[i] = ~m_level[i];
              m_run[i]   = 0;
              if (m_level[i]) t_nr[i] = 1'b1;
              else            t_nf[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_rise = t_nr;
      m_fall = t_nf;
      m_sync = m_meta;
      m_meta = raw;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", level, m_level);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("rise_flag", rise_flag, m_rflag);
      check("fall_flag", fall_flag, m_fflag);
      check("irq", irq, m_irq);
    end
  end

  // Inputs change 1 time unit after the falling edge, clear of both compare and clock edges.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int         cnt;
  logic [6:0] anyev;

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    step(3);
    rst_n = 1'b1;
    sample_en = 1'b1;

    // Reset level and quiet period with raw matching the reset level.
    check("reset_level", level, 7'b0001001);
    anyev = '0;
    repeat (100) begin
      step(1);
      anyev |= rise | fall | rise_flag | fall_flag | {6'd0, irq};
    end
    check("quiet_events", anyev, 7'd0);
    check("quiet_level", level, 7'b0001001);

    // Clean step on channel 2.
    raw[2] = 1'b1;
    step(5);
    check("step_level_before", level[2], 1'b0);
    step(1);
    check("step_level", level[2], 1'b1);
    check("step_rise", rise[2], 1'b1);
    step(1);
    check("step_rise_gone", rise[2], 1'b0);
`ifdef DEBOUNCE_EDGE_LATCH_EN
    check("step_irq_lag", irq, 1'b0);
    step(1);
    check("step_irq", irq, 1'b1);
`else
    check("step_irq", irq, 1'b1);
`endif

    // Bounce on channel 0 with a strobe every 4th cycle.
    raw[0] = 1'b0;
    step(8);
    check("bounce_pre_level", level[0], 1'b0);
    cnt = 0;
    for (int c = 0; c < 36; c++) begin
      sample_en = (c % 4 == 0);
      raw[0] = (c >= 8 && c < 12) ? 1'b0 : 1'b1;
      step(1);
      if (c < 28 && rise[0]) cnt++;
      if (c == 27) check("bounce_level_hold", level[0], 1'b0);
      if (c == 28) check("bounce_rise", rise[0], 1'b1);
    end
    check("bounce_no_early_pulse", cnt, 0);
    sample_en = 1'b1;

    // Simultaneous rise on channel 1 and fall on channel 3.
    raw[1] = 1'b1;
    raw[3] = 1'b0;
    step(6);
    check("simul_pulses", {rise[1], fall[3]}, 2'b11);
    cnt = 0;
    repeat (5) begin
      step(1);
      cnt += int'(irq);
    end
`ifdef DEBOUNCE_EDGE_LATCH_EN
    check("simul_irq_cycles", cnt, 5);
`else
    check("simul_irq_cycles", cnt, 1);
`endif

    // Reset in the middle of a check on channel 4.
    raw[4] = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    check("midrst_level", level, 7'b0001001);
    check("midrst_pulses", rise | fall, 7'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check("midrst_restart_hold", level[4], 1'b0);
    step(1);
    check("midrst_restart_level", level[4], 1'b1);
    check("midrst_restart_rise", rise[4], 1'b1);
    step(3);

`ifdef DEBOUNCE_EDGE_LATCH_EN
    flag_clr = '1;
    step(1);
    flag_clr = '0;
    step(1);
    check("latch_irq_cleared", irq, 1'b0);
    raw[5] = 1'b1;
    step(6);
    check("latch_rise5", rise[5], 1'b1);
    step(1);
    check("latch_flag5", rise_flag[5], 1'b1);
    step(1);
    check("latch_irq", irq, 1'b1);
    step(5);
    check("latch_flag5_sticky", rise_flag[5], 1'b1);
    check("latch_irq_sticky", irq, 1'b1);
    flag_clr[5] = 1'b1;
    step(1);
    flag_clr = '0;
    check("clr_flag5", rise_flag[5], 1'b0);
    check("clr_irq_lag", irq, 1'b1);
    step(1);
    check("clr_irq", irq, 1'b0);
    raw[5] = 1'b0;
    step(8);
    flag_clr = '1;
    step(1);
    flag_clr = '0;
    raw[5] = 1'b1;
    step(6);
    check("setwin_rise5", rise[5], 1'b1);
    flag_clr[5] = 1'b1;
    step(1);
    flag_clr = '0;
    check("setwin_flag5", rise_flag[5], 1'b1);
`endif

    // Randomized phase: bouncy inputs, irregular strobes, random clears, rare resets.
    for (int c = 0; c < 4000; c++) begin
      sample_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) raw ^= 7'(1 << $urandom_range(0, 6));
      flag_clr = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
      rst_n = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
